// File: rtl/parity_pkg.sv
// Shared types for the streaming parity accumulator: result polarity codes and FSM states.
package parity_pkg;

  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/parity_tree.sv
// Balanced XOR-reduction tree; each node is a 2:1 mux acting as an XOR cell.
module parity_tree #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             par_o
);

  localparam int unsigned LO = WIDTH / 2;
  localparam int unsigned HI = WIDTH - LO;

  generate
    if (WIDTH == 1) begin : g_leaf
      assign par_o = data_i[0];
    end else begin : g_node
      logic lo_par;
      logic hi_par;

      parity_tree #(.WIDTH(LO)) u_lo (
        .data_i (data_i[LO-1:0]),
        .par_o  (lo_par)
      );

      parity_tree #(.WIDTH(HI)) u_hi (
        .data_i (data_i[WIDTH-1:LO]),
        .par_o  (hi_par)
      );

      // Upper half selects true or inverted lower half.
      assign par_o = hi_par ? ~lo_par : lo_par;
    end
  endgenerate

endmodule

// File: rtl/parity_stream_acc.sv
// Frame-wise XOR/XNOR parity accumulator with valid/ready on both sides.
// Optional expected-parity check enabled by macro PARITY_STREAM_CHECK_EN.
module parity_stream_acc
  import parity_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned MAX_WORDS = 16,
  localparam int unsigned CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef PARITY_STREAM_CHECK_EN
  input  logic             in_par_exp,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic [CW-1:0]    out_cnt,
  output logic             out_ovf
);

  state_e        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          ovf_q, ovf_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_par_q, out_par_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          out_ovf_q, out_ovf_d;
  logic          wp;
  logic          beat_c;
  logic          load_c;

  parity_tree #(.WIDTH(WIDTH)) u_tree (
    .data_i (in_data),
    .par_o  (wp)
  );

  assign beat_c = in_valid && in_ready_q;

`ifdef PARITY_STREAM_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    ovf_d       = ovf_q;
    out_par_d   = out_par_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;
`ifdef PARITY_STREAM_CHECK_EN
    err_d       = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (beat_c) begin
          acc_d   = wp;
          cnt_d   = CW'(1);
          mode_d  = mode;
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (beat_c) begin
          acc_d = acc_q ^ wp;
          // Counter saturates; the overflow flag stays set until the next frame.
          if (cnt_q == CW'(MAX_WORDS)) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          state_d = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);

    // Result registers capture once, on entry to HOLD, and then hold.
    load_c = (state_q != HOLD) && (state_d == HOLD);
    if (load_c) begin
      out_par_d = acc_d ^ mode_d;
      out_cnt_d = cnt_d;
      out_ovf_d = ovf_d;
`ifdef PARITY_STREAM_CHECK_EN
      err_d     = (acc_d ^ mode_d) != in_par_exp;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= MODE_XOR;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
`ifdef PARITY_STREAM_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_par_q   <= out_par_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
`ifdef PARITY_STREAM_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_par   = out_par_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;
`ifdef PARITY_STREAM_CHECK_EN
  assign out_err   = err_q;
`endif

endmodule

// File: tb/tb_parity_stream_acc.sv
// Bench for parity_stream_acc: directed frames plus randomized frames against a frame-level model.
module tb_parity_stream_acc;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned CW        = $clog2(MAX_WORDS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_par;
  logic [CW-1:0]    out_cnt;
  logic             out_ovf;
`ifdef PARITY_STREAM_CHECK_EN
  logic             in_par_exp = 1'b0;
  logic             out_err;
  int               pe_sel = -1;
`endif

  always #5 clk = ~clk;

  parity_stream_acc #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
`ifdef PARITY_STREAM_CHECK_EN
    .in_par_exp (in_par_exp),
    .out_err    (out_err),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_par    (out_par),
    .out_cnt    (out_cnt),
    .out_ovf    (out_ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: counts words and ones per frame, result pending until handshake.
  bit m_valid;
  bit m_par;
  int m_cnt;
  bit m_ovf;
  bit m_err;
  int fr_words;
  int fr_ones;
  bit fr_mode;
  int settle;

  always @(posedge clk or negedge rst_n) begin : model
    bit was_valid;
    if (!rst_n) begin
      m_valid  = 1'b0;
      m_par    = 1'b0;
      m_cnt    = 0;
      m_ovf    = 1'b0;
      m_err    = 1'b0;
      fr_words = 0;
      fr_ones  = 0;
      settle   = 0;
    end else begin
      was_valid = m_valid;
      if (settle < 4) settle++;
      if (was_valid && out_ready) m_valid = 1'b0;
      if (in_valid && !was_valid) begin
        if (fr_words == 0) fr_mode = mode;
        fr_words++;
        fr_ones += $countones(in_data);
        if (in_last) begin
          m_par   = bit'(fr_ones % 2) ^ fr_mode;
          m_cnt   = (fr_words > int'(MAX_WORDS)) ? int'(MAX_WORDS) : fr_words;
          m_ovf   = fr_words > int'(MAX_WORDS);
`ifdef PARITY_STREAM_CHECK_EN
          m_err   = m_par != in_par_exp;
`else
          m_err   = 1'b0;
`endif
          m_valid = 1'b1;
          fr_words = 0;
          fr_ones  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && settle >= 1) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid));
      if (m_valid) begin
        chk("out_par", 32'(out_par), 32'(m_par));
        chk("out_cnt", 32'(out_cnt), 32'(m_cnt));
        chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
`ifdef PARITY_STREAM_CHECK_EN
        chk("out_err", 32'(out_err), 32'(m_err));
`endif
      end
    end
  end

  // Called and returns at posedge+1; leaves the beat accepted and in_valid low.
  task automatic beat(input logic [WIDTH-1:0] d, input logic last, input logic m);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
`ifdef PARITY_STREAM_CHECK_EN
    in_par_exp = (pe_sel < 0) ? 1'($urandom_range(0, 1)) : pe_sel[0];
`endif
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("beat_accept_timeout", 32'(got), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_data  = WIDTH'($urandom);
    mode     = 1'($urandom_range(0, 1));
  endtask

  // Result must be visible at the first negedge after the last beat; exits at posedge+1.
  task automatic frame_check(input string name, input logic ep, input int ec, input logic eo);
    @(negedge clk);
    chk({name, "_latency"}, 32'(out_valid), 32'd1);
    chk({name, "_par"}, 32'(out_par), 32'(ep));
    chk({name, "_cnt"}, 32'(out_cnt), 32'(ec));
    chk({name, "_ovf"}, 32'(out_ovf), 32'(eo));
    chk({name, "_model_par"}, 32'(m_par), 32'(ep));
  endtask

  task automatic to_phase();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] xnor_tbl = 8'h69;
  bit         rand_on  = 1'b0;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_par", 32'(out_par), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) to_phase();

    beat(8'hA5, 1'b1, 1'b0);
    frame_check("a5_xor", 1'b0, 1, 1'b0);
    to_phase();
    beat(8'hA5, 1'b1, 1'b1);
    frame_check("a5_xnor", 1'b1, 1, 1'b0);
    to_phase();

    // Later beats carry mode=1, which must be ignored mid-frame.
    beat(8'h01, 1'b0, 1'b0);
    beat(8'h03, 1'b0, 1'b1);
    beat(8'h07, 1'b1, 1'b1);
    frame_check("three_word", 1'b0, 3, 1'b0);
    to_phase();

    out_ready = 1'b0;
    beat(8'h07, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    mode     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_par", 32'(out_par), 32'd1);
      chk("bp_cnt", 32'(out_cnt), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    to_phase();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_par", 32'(out_par), 32'd0);
    chk("bp_next_cnt", 32'(out_cnt), 32'd1);
    to_phase();

    for (int i = 0; i < 16; i++) beat(8'h01, 1'b0, 1'b0);
    beat(8'h01, 1'b1, 1'b0);
    frame_check("ovf", 1'b1, 16, 1'b1);
    to_phase();

    beat(8'h01, 1'b0, 1'b0);
    beat(8'h02, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_par", 32'(out_par), 32'd0);
    chk("midrst_cnt", 32'(out_cnt), 32'd0);
    chk("midrst_ovf", 32'(out_ovf), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) to_phase();
    beat(8'h80, 1'b1, 1'b0);
    frame_check("post_rst", 1'b1, 1, 1'b0);
    to_phase();

    for (int v = 0; v < 8; v++) begin
      for (int e = 0; e < 2; e++) begin
`ifdef PARITY_STREAM_CHECK_EN
        pe_sel = (e == 1) ? int'(~xnor_tbl[v]) & 1 : int'(xnor_tbl[v]);
`endif
        beat(WIDTH'(v), 1'b1, 1'b1);
        frame_check("xnor3", xnor_tbl[v], 1, 1'b0);
`ifdef PARITY_STREAM_CHECK_EN
        chk("xnor3_err", 32'(out_err), 32'(e));
`endif
        to_phase();
      end
    end
`ifdef PARITY_STREAM_CHECK_EN
    pe_sel = -1;
`endif

    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int f = 0; f < 150; f++) begin
      int len;
      bit m;
      len = int'($urandom_range(1, 20));
      m   = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) to_phase();
        beat(WIDTH'($urandom), i == len - 1, (i == 0) ? m : 1'($urandom_range(0, 1)));
      end
    end
    rand_on = 1'b0;
    to_phase();
    out_ready = 1'b1;
    repeat (5) to_phase();
    chk("drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
